axil_read_master: RTL and testbench
===================================

Name: axil_read_master

Overview:
AXI4-Lite master-side read engine, the initiator counterpart to the slave R channel.
- Accepts a single-word read request on a local valid/ready interface.
- Issues it on the AR channel, accepts the response beat on the R channel, and returns data and response to the local user.
- Sits between on-chip control logic (CPU bridge, sequencer) and the AXI4-Lite interconnect.
- One outstanding transaction; includes an R-channel timeout watchdog.

Parameters:
ADDR_WIDTH, 32, width of ARADDR and req_addr
DATA_WIDTH, 32, width of RDATA and rsp_data (32 or 64)
TIMEOUT_CYCLES, 256, cycles to wait for RVALID after the AR handshake; 0 disables the watchdog

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
req_valid  input  1  user read request valid
req_ready  output  1  engine can accept a request
req_addr  input  ADDR_WIDTH  read address
req_prot  input  3  protection bits forwarded to ARPROT
rsp_valid  output  1  response available to user
rsp_ready  input  1  user accepts response
rsp_data  output  DATA_WIDTH  read data
rsp_resp  output  2  AXI response code
rsp_timeout  output  1  response produced by watchdog, not by slave
ARVALID  output  1  read address valid
ARREADY  input  1  slave accepts address
ARADDR  output  ADDR_WIDTH  read address
ARPROT  output  3  protection
RVALID  input  1  slave read data valid
RREADY  output  1  master ready for read data
RDATA  input  DATA_WIDTH  read data
RRESP  input  2  read response

Behaviour:
Reset and outputs
- Reset: clk, asynchronous active-low resetn.
- All outputs are registered.
- While resetn is low, all outputs are 0, the FSM is in IDLE, the drain flag is 0 and the counter is 0.
- Reset mid-transaction abandons it immediately; no AR/R handshake completes.

FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - req_ready = 1 unless drain_pending.
  - On req_valid && req_ready: latch addr/prot into ARADDR/ARPROT, go to ADDR.
  - ARVALID is high in the cycle after acceptance.
- ADDR:
  - ARVALID = 1, ARADDR/ARPROT stable.
  - ARVALID never drops before ARREADY; there is no timeout in ADDR.
  - On ARREADY: ARVALID = 0 next cycle, go to DATA; RREADY = 1 from the next cycle.
- DATA:
  - RREADY = 1; the counter increments each cycle.
  - On RVALID: capture RDATA/RRESP into rsp_data/rsp_resp, rsp_timeout = 0, RREADY = 0, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES with no RVALID:
    - rsp_data = 0, rsp_resp = 2'b10 (SLVERR), rsp_timeout = 1.
    - Set drain_pending; go to RESP.
  - RVALID in the same cycle as the timeout: the beat wins, normal capture, no drain.
- RESP:
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On rsp_ready: rsp_valid = 0 next cycle, go to IDLE, clear the counter.
- Drain:
  - While drain_pending, RREADY = 1 in every state other than DATA, and req_ready = 0.
  - The late R beat is accepted and discarded, which clears drain_pending.
  - New requests are blocked until the late beat arrives.

Latency
- Request accepted at cycle N: ARVALID at N+1.
- AR handshake at cycle A: RREADY at A+1.
- R handshake at cycle M: rsp_valid at M+1.
- Minimum request-to-response: 3 cycles with ARREADY and RVALID tied high.

Boundary conditions
- req_valid while busy is ignored, since req_ready = 0.
- RVALID while in ADDR is not accepted (RREADY = 0) and waits for DATA.
- RRESP codes EXOKAY, SLVERR and DECERR pass through unchanged; data is forwarded regardless of RRESP.
- The counter width is clog2(TIMEOUT_CYCLES+1) and saturates; it never wraps.

Decomposition:
- Shared package axil_pkg:
  - RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - State encodings IDLE/ADDR/DATA/RESP (2-bit).
  - Default PROT = 3'b000.
- One sub-module: axil_timeout_ctr.
  - Parameterised by TIMEOUT_CYCLES, with enable, clear and expired outputs.
  - Reused later by the write master.

Test Plan:
- ARREADY and RVALID tied 1, request addr 0x0000_0010 with RDATA 0xDEADBEEF / RRESP 00 -> ARVALID at N+1 with ARADDR 0x10; rsp_valid at N+3 with data 0xDEADBEEF, resp 00, timeout 0.
- ARREADY delayed 5 cycles -> ARVALID held high and ARADDR stable for all 5 cycles; exactly one AR handshake.
- RVALID arrives with RRESP 11, RDATA 0x12345678 -> rsp_resp 11, rsp_data 0x12345678, rsp_timeout 0.
- TIMEOUT_CYCLES = 8, RVALID never asserted -> after 8 DATA cycles: rsp_resp 10, rsp_timeout 1, req_ready 0; RVALID pulsed 4 cycles later is absorbed with RREADY 1; req_ready returns to 1.
- rsp_ready held low 10 cycles -> rsp_valid and rsp_data stable for all cycles; req_ready 0 throughout.
- resetn pulsed low while in DATA -> ARVALID, RREADY, rsp_valid and req_ready all 0 immediately; after release, req_ready 1 next cycle and a new read completes normally.

Source files
------------

// File: rtl/axil_pkg.sv
// ============================================================================
// Module      : axil_pkg
// Description : Shared AXI4-Lite constants and FSM encodings for the masters.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

`default_nettype wire

// File: rtl/axil_timeout_ctr.sv
// ============================================================================
// Module      : axil_timeout_ctr
// Description : Saturating cycle counter; expired flags the last allowed cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axil_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = ^{clk, resetn, enable, clear};
            assign expired  = 1'b0;
        end else begin : g_enabled
            localparam int c_CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [c_CW-1:0] c_MAX  = c_CW'(TIMEOUT_CYCLES);
            localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT_CYCLES - 1);

            logic [c_CW-1:0] r_count;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (enable && (r_count != c_MAX)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Asserted during the TIMEOUT_CYCLES-th enabled cycle so the
            // owner can leave its wait state on that same edge.
            assign expired = enable && (r_count >= c_LAST);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/axil_read_master.sv
// ============================================================================
// Module      : axil_read_master
// Description : Single-outstanding AXI4-Lite read initiator with R watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axil_read_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [2:0]            ARPROT,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_drain;
    logic       w_drain_nxt;
    logic       w_capture;
    logic       w_timeout_fire;
    logic       w_expired;

    logic       w_req_hs;
    logic       w_ar_hs;
    logic       w_r_hs;
    logic       w_rsp_hs;

    assign w_req_hs = req_valid && req_ready;
    assign w_ar_hs  = ARVALID && ARREADY;
    assign w_r_hs   = RVALID && RREADY;
    assign w_rsp_hs = rsp_valid && rsp_ready;

    axil_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .resetn  (resetn),
        .enable  (r_state == S_DATA),
        .clear   (w_rsp_hs),
        .expired (w_expired)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_drain_nxt    = r_drain;
        w_capture      = 1'b0;
        w_timeout_fire = 1'b0;
        case (r_state)
            S_IDLE: if (w_req_hs) w_state_nxt = S_ADDR;
            S_ADDR: if (w_ar_hs)  w_state_nxt = S_DATA;
            S_DATA: begin
                // A beat arriving on the expiry cycle takes priority.
                if (w_r_hs) begin
                    w_state_nxt = S_RESP;
                    w_capture   = 1'b1;
                end else if (w_expired) begin
                    w_state_nxt    = S_RESP;
                    w_drain_nxt    = 1'b1;
                    w_timeout_fire = 1'b1;
                end
            end
            S_RESP: if (w_rsp_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // The abandoned transaction's late beat is swallowed outside DATA.
        if (r_drain && w_r_hs && (r_state != S_DATA)) begin
            w_drain_nxt = 1'b0;
        end
    end

    // Every output is decoded from the next state so it is a flop output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_drain     <= 1'b0;
            req_ready   <= 1'b0;
            ARVALID     <= 1'b0;
            RREADY      <= 1'b0;
            rsp_valid   <= 1'b0;
            ARADDR      <= '0;
            ARPROT      <= PROT_DEFAULT;
            rsp_data    <= '0;
            rsp_resp    <= RESP_OKAY;
            rsp_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_drain   <= w_drain_nxt;
            req_ready <= (w_state_nxt == S_IDLE) && !w_drain_nxt;
            ARVALID   <= (w_state_nxt == S_ADDR);
            RREADY    <= (w_state_nxt == S_DATA) || w_drain_nxt;
            rsp_valid <= (w_state_nxt == S_RESP);
            if (w_req_hs) begin
                ARADDR <= req_addr;
                ARPROT <= req_prot;
            end
            if (w_capture) begin
                rsp_data    <= RDATA;
                rsp_resp    <= RRESP;
                rsp_timeout <= 1'b0;
            end else if (w_timeout_fire) begin
                rsp_data    <= '0;
                rsp_resp    <= RESP_SLVERR;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axil_read_master.sv
// ============================================================================
// Module      : tb_axil_read_master
// Description : Directed and randomized self-checking bench for the read master.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axil_read_master;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int TO     = 8;
    localparam int N_RAND = 200;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [2:0]    req_prot = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic          ARVALID;
    logic          ARREADY = 1'b0;
    logic [AW-1:0] ARADDR;
    logic [2:0]    ARPROT;
    logic          RVALID = 1'b0;
    logic          RREADY;
    logic [DW-1:0] RDATA = '0;
    logic [1:0]    RRESP = '0;

    axil_read_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_prot    (req_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .ARADDR      (ARADDR),
        .ARPROT      (ARPROT),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .RDATA       (RDATA),
        .RRESP       (RRESP)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ar_hs  = 0;
    int r_hs   = 0;

    always @(posedge clk) begin
        if (resetn && ARVALID && ARREADY) ar_hs <= ar_hs + 1;
        if (resetn && RVALID && RREADY)   r_hs  <= r_hs + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: queued requests, queued slave beats.
    logic [AW-1:0]   q_addr[$];
    logic [2:0]      q_prot[$];
    logic [DW+1:0]   q_rsp[$];
    logic [DW+1:0]   exp_rsp;
    logic [DW-1:0]   h_data;
    logic [1:0]      h_resp;
    bit              held, r_pend;
    bit              req_h, ar_h, r_h, p_h, v_now;
    int              r_wait, n_req, n_done, n_ar, base_ar, base_r;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("rst_arprot", ARPROT, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_resp", rsp_resp, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        @(negedge clk) resetn = 1'b1;
        tick();
        chk("rel_req_ready", req_ready, 1);

        // ---------------- minimum latency, tied handshakes ----------------
        ARREADY = 1; RVALID = 1; RDATA = 32'hDEADBEEF; RRESP = 2'b00;
        req_valid = 1; req_addr = 32'h0000_0010; req_prot = 3'b010;
        base_ar = ar_hs;
        tick();
        req_valid = 0;
        chk("lat_arvalid_n1", ARVALID, 1);
        chk("lat_araddr", ARADDR, 32'h10);
        chk("lat_arprot", ARPROT, 3'b010);
        chk("lat_req_ready_busy", req_ready, 0);
        tick();
        chk("lat_arvalid_n2", ARVALID, 0);
        chk("lat_rready_n2", RREADY, 1);
        chk("lat_rsp_valid_n2", rsp_valid, 0);
        tick();
        chk("lat_rsp_valid_n3", rsp_valid, 1);
        chk("lat_rsp_data", rsp_data, 32'hDEADBEEF);
        chk("lat_rsp_resp", rsp_resp, 2'b00);
        chk("lat_rsp_timeout", rsp_timeout, 0);
        chk("lat_rready_n3", RREADY, 0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0; ARREADY = 0; RVALID = 0;
        chk("lat_rsp_done", rsp_valid, 0);
        chk("lat_req_ready_back", req_ready, 1);
        chk("lat_ar_count", ar_hs - base_ar, 1);

        // ---------- delayed ARREADY, early RVALID, DECERR pass-through ----------
        req_valid = 1; req_addr = 32'h0000_1234; req_prot = 3'b101;
        base_ar = ar_hs;
        tick();
        req_valid = 0; req_addr = 32'hFFFF_FFFF;
        RVALID = 1; RDATA = 32'h12345678; RRESP = 2'b11;
        for (int i = 0; i < 5; i++) begin
            chk("dly_arvalid", ARVALID, 1);
            chk("dly_araddr", ARADDR, 32'h1234);
            chk("dly_arprot", ARPROT, 3'b101);
            chk("dly_rready_in_addr", RREADY, 0);
            tick();
        end
        ARREADY = 1;
        chk("dly_arvalid_last", ARVALID, 1);
        tick();
        ARREADY = 0;
        chk("dly_arvalid_drop", ARVALID, 0);
        chk("dly_rready", RREADY, 1);
        tick();
        RVALID = 0;
        chk("err_rsp_valid", rsp_valid, 1);
        chk("err_rsp_data", rsp_data, 32'h12345678);
        chk("err_rsp_resp", rsp_resp, 2'b11);
        chk("err_rsp_timeout", rsp_timeout, 0);
        chk("dly_ar_count", ar_hs - base_ar, 1);

        // ---------------- response back-pressure ----------------
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 32'h12345678);
            chk("bp_rsp_resp", rsp_resp, 2'b11);
            chk("bp_req_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("bp_rsp_done", rsp_valid, 0);
        chk("bp_req_ready_back", req_ready, 1);

        // ---------------- watchdog expiry and drain ----------------
        ARREADY = 1; RVALID = 0;
        req_valid = 1; req_addr = 32'h0000_0040; req_prot = 3'b000;
        tick();
        req_valid = 0;
        chk("to_arvalid", ARVALID, 1);
        tick();
        ARREADY = 0;
        for (int k = 0; k < TO; k++) begin
            chk("to_wait_rsp_valid", rsp_valid, 0);
            chk("to_wait_rready", RREADY, 1);
            tick();
        end
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_resp", rsp_resp, 2'b10);
        chk("to_rsp_timeout", rsp_timeout, 1);
        chk("to_rsp_data", rsp_data, 0);
        chk("to_req_ready", req_ready, 0);
        chk("to_rready_drain", RREADY, 1);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("drain_rsp_valid", rsp_valid, 0);
        chk("drain_req_ready", req_ready, 0);
        chk("drain_rready_idle", RREADY, 1);
        req_valid = 1; req_addr = 32'h0000_0080;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("drain_blocked_req_ready", req_ready, 0);
            chk("drain_blocked_arvalid", ARVALID, 0);
        end
        RVALID = 1; RDATA = 32'hCAFEF00D; RRESP = 2'b00;
        base_r = r_hs;
        tick();
        RVALID = 0; req_valid = 0;
        chk("drain_absorbed", r_hs - base_r, 1);
        chk("drain_req_ready_back", req_ready, 1);
        chk("drain_rready_off", RREADY, 0);
        chk("drain_no_rsp", rsp_valid, 0);
        tick();
        chk("drain_no_accept", ARVALID, 0);

        // ---------------- reset in DATA ----------------
        ARREADY = 1;
        req_valid = 1; req_addr = 32'h0000_0100;
        tick();
        req_valid = 0;
        tick();
        ARREADY = 0;
        chk("mid_rready_pre", RREADY, 1);
        resetn = 0;
        #1;
        chk("mid_arvalid", ARVALID, 0);
        chk("mid_rready", RREADY, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_req_ready", req_ready, 0);
        tick();
        @(negedge clk) resetn = 1'b1;
        tick();
        chk("mid_req_ready_rel", req_ready, 1);
        ARREADY = 1; RVALID = 1; RDATA = 32'hA5A5_0001; RRESP = 2'b01;
        req_valid = 1; req_addr = 32'h0000_0200;
        tick();
        req_valid = 0;
        tick(); tick();
        chk("mid_after_rsp_valid", rsp_valid, 1);
        chk("mid_after_rsp_data", rsp_data, 32'hA5A5_0001);
        chk("mid_after_rsp_resp", rsp_resp, 2'b01);
        rsp_ready = 1;
        tick();
        rsp_ready = 0; ARREADY = 0; RVALID = 0;

        // ---------------- randomized traffic vs transaction model ----------------
        held = 0; r_pend = 0; r_wait = 0; n_req = 0; n_done = 0; n_ar = 0;
        for (int c = 0; c < 20000 && n_done < N_RAND; c++) begin
            if (!req_valid && n_req < N_RAND && $urandom_range(0, 2) == 0) begin
                req_valid = 1;
                req_addr  = $urandom;
                req_prot  = 3'($urandom_range(0, 7));
            end
            ARREADY = 1'($urandom_range(0, 1));
            if (ARVALID) begin
                if (q_addr.size() == 0) chk("rand_ar_unexpected", 1, 0);
                else begin
                    chk("rand_araddr", ARADDR, q_addr[0]);
                    chk("rand_arprot", ARPROT, q_prot[0]);
                end
            end
            // Beat delay stays well under the watchdog limit.
            if (r_pend && !RVALID) begin
                if (r_wait == 0) begin
                    RVALID = 1;
                    RDATA  = $urandom;
                    RRESP  = 2'($urandom_range(0, 3));
                end else r_wait--;
            end
            rsp_ready = 1'($urandom_range(0, 1));
            if (rsp_valid) begin
                if (!held) begin
                    if (q_rsp.size() == 0) chk("rand_rsp_unexpected", 1, 0);
                    else begin
                        exp_rsp = q_rsp[0];
                        chk("rand_rsp_data", rsp_data, exp_rsp[DW-1:0]);
                        chk("rand_rsp_resp", rsp_resp, exp_rsp[DW+1:DW]);
                        chk("rand_rsp_timeout", rsp_timeout, 0);
                    end
                end else begin
                    chk("rand_rsp_stable", {rsp_resp, rsp_data}, {h_resp, h_data});
                end
            end
            req_h = req_valid && req_ready;
            ar_h  = ARVALID && ARREADY;
            r_h   = RVALID && RREADY;
            p_h   = rsp_valid && rsp_ready;
            v_now = rsp_valid;
            h_data = rsp_data;
            h_resp = rsp_resp;
            tick();
            if (req_h) begin
                q_addr.push_back(req_addr);
                q_prot.push_back(req_prot);
                req_valid = 0;
                n_req++;
            end
            if (ar_h && q_addr.size() != 0) begin
                void'(q_addr.pop_front());
                void'(q_prot.pop_front());
                r_pend = 1;
                r_wait = $urandom_range(0, 4);
                n_ar++;
            end
            if (r_h) begin
                q_rsp.push_back({RRESP, RDATA});
                RVALID = 0;
                r_pend = 0;
            end
            if (p_h) begin
                if (q_rsp.size() != 0) void'(q_rsp.pop_front());
                n_done++;
                held = 0;
            end else if (v_now) begin
                held = 1;
            end
        end
        req_valid = 0; RVALID = 0; ARREADY = 0; rsp_ready = 0;
        chk("rand_done_count", n_done, N_RAND);
        chk("rand_ar_count", n_ar, N_RAND);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
